// File: rtl/subs_layer_seq.sv
// subs_layer_seq: iterative SPN substitution layer.
// Applies the 4-bit cipher S-box (or its inverse) to every nibble of a
// SIZE-bit block, LANES nibbles per clock, least-significant nibble first.
// Valid/ready handshakes on both sides; one block in flight at a time.
module subs_layer_seq #(
  parameter int SIZE  = 16,
  parameter int LANES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  input  logic            inverse,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_data,
  output logic            busy
);

  localparam int NIB = SIZE / 4;
  localparam int K   = NIB / LANES;
  localparam int CW  = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  fsm_e            fsm_q, fsm_d;
  logic [SIZE-1:0] state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sub_nib(input logic [3:0] x, input logic inv);
    return inv ? sbox_inv(x) : sbox_fwd(x);
  endfunction

  // Outputs decode from FSM state only; in_ready is also held low during reset.
  assign in_ready  = reset && (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign out_data  = state_q;

  // Next-state and datapath: load on accept, substitute one lane group per cycle.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = in_data;
          mode_d  = inverse;
          cnt_d   = '0;
          fsm_d   = SUB;
        end
      end
      SUB: begin
        for (int l = 0; l < LANES; l++) begin
          state_d[(int'(cnt_q) * LANES + l) * 4 +: 4] =
            sub_nib(state_q[(int'(cnt_q) * LANES + l) * 4 +: 4], mode_q);
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(K - 1)) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // FSM state register; asynchronous reset returns to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Working state, lane counter and latched mode; cleared on reset so a partial result never survives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_subs_layer_seq.sv
// Directed bench for subs_layer_seq: a 16-bit single-lane instance and a
// 64-bit four-lane instance sharing clock and reset.
module tb_subs_layer_seq;

  logic        clk = 1'b0;
  logic        reset;

  logic        a_in_valid, a_in_ready, a_inverse, a_out_valid, a_out_ready, a_busy;
  logic [15:0] a_in_data, a_out_data;

  logic        b_in_valid, b_in_ready, b_inverse, b_out_valid, b_out_ready, b_busy;
  logic [63:0] b_in_data, b_out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  subs_layer_seq #(.SIZE(16), .LANES(1)) u_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .inverse(a_inverse),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
  );

  subs_layer_seq #(.SIZE(64), .LANES(4)) u_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .inverse(b_inverse),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push one block through the 16-bit instance with out_ready high and check result and latency.
  task automatic run_a(input string tag, input logic [15:0] din, input logic inv,
                       input logic [15:0] exp);
    int lat;
    lat = 0;
    a_in_data   = din;
    a_inverse   = inv;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    step();
    a_in_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (a_out_valid) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_data"}, 64'(a_out_data), 64'(exp));
    step();
    chk({tag, "_idle"}, 64'(a_busy), 64'd0);
  endtask

  // Same for the 64-bit four-lane instance.
  task automatic run_b(input string tag, input logic [63:0] din, input logic inv,
                       input logic [63:0] exp);
    int lat;
    lat = 0;
    b_in_data   = din;
    b_inverse   = inv;
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    step();
    b_in_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (b_out_valid) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_data"}, b_out_data, exp);
    step();
    chk({tag, "_idle"}, 64'(b_busy), 64'd0);
  endtask

  initial begin
    reset       = 1'b0;
    a_in_valid  = 1'b0; a_in_data = '0; a_inverse = 1'b0; a_out_ready = 1'b0;
    b_in_valid  = 1'b0; b_in_data = '0; b_inverse = 1'b0; b_out_ready = 1'b1;

    // Reset state, before any clock edge
    #1;
    chk("rst_data",  64'(a_out_data),  64'd0);
    chk("rst_valid", 64'(a_out_valid), 64'd0);
    chk("rst_busy",  64'(a_busy),      64'd0);
    chk("rst_ready", 64'(a_in_ready),  64'd0);
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rel_ready", 64'(a_in_ready), 64'd1);

    // Forward 0x0123 with exact latency, then backpressure in DONE
    a_in_data   = 16'h0123;
    a_inverse   = 1'b0;
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    step();
    a_in_valid = 1'b0;
    chk("acc_busy", 64'(a_busy), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("sub_nvalid", 64'(a_out_valid), 64'd0);
      chk("sub_busy",   64'(a_busy),      64'd1);
    end
    step();
    chk("fwd_valid", 64'(a_out_valid), 64'd1);
    chk("fwd_data",  64'(a_out_data),  64'hC56B);

    a_in_data  = 16'hAAAA;
    a_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 4) a_in_valid = 1'b0;
      chk("bp_valid", 64'(a_out_valid), 64'd1);
      chk("bp_data",  64'(a_out_data),  64'hC56B);
      chk("bp_ready", 64'(a_in_ready),  64'd0);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    step();
    chk("bp_rel_valid", 64'(a_out_valid), 64'd0);
    chk("bp_rel_ready", 64'(a_in_ready),  64'd1);
    chk("bp_rel_busy",  64'(a_busy),      64'd0);

    // Inverse round trip and all-ones forward
    run_a("inv_c56b", 16'hC56B, 1'b1, 16'h0123);
    run_a("fwd_ffff", 16'hFFFF, 1'b0, 16'h2222);

    // Wide four-lane instance, forward and back
    run_b("wide_fwd", 64'h0123456789ABCDEF, 1'b0, 64'hC56B90AD3EF84712);
    run_b("wide_inv", 64'hC56B90AD3EF84712, 1'b1, 64'h0123456789ABCDEF);

    // Mode latch and back-to-back initiation interval
    a_in_data   = 16'h0123;
    a_inverse   = 1'b0;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    step();
    a_inverse = 1'b1;
    chk("b2b_acc1", 64'(a_busy), 64'd1);
    for (int i = 1; i <= 3; i++) step();
    step();
    chk("b2b_valid", 64'(a_out_valid), 64'd1);
    chk("b2b_data",  64'(a_out_data),  64'hC56B);
    step();
    chk("b2b_idle",  64'(a_busy),     64'd0);
    chk("b2b_ready", 64'(a_in_ready), 64'd1);
    step();
    a_in_valid = 1'b0;
    chk("b2b_acc2", 64'(a_busy), 64'd1);
    for (int i = 1; i <= 3; i++) step();
    step();
    chk("b2b2_valid", 64'(a_out_valid), 64'd1);
    chk("b2b2_data",  64'(a_out_data),  64'h5EF8);
    step();

    // Asynchronous reset in the second SUB cycle
    a_in_data  = 16'h1234;
    a_inverse  = 1'b0;
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_data",  64'(a_out_data),  64'd0);
    chk("arst_valid", 64'(a_out_valid), 64'd0);
    chk("arst_busy",  64'(a_busy),      64'd0);
    chk("arst_ready", 64'(a_in_ready),  64'd0);
    step();
    reset = 1'b1;
    #1;
    run_a("post_rst", 16'h4567, 1'b0, 16'h90AD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/subs_layer_seq.md
# subs_layer_seq

Iterative, parametrised substitution layer for the SPN cipher datapath. It applies the 4-bit cipher S-box, or its inverse, to every nibble of a `SIZE`-bit state, `LANES` nibbles per clock. Valid/ready handshakes on both sides let it sit between the round-key mixing stage and the permutation layer. It trades area against latency relative to the fully combinational substitution layer, and adds decryption (inverse) mode.

## Interface

Parameters:

- `SIZE`, default 16: state width in bits; must be a multiple of 4.
- `LANES`, default 1: S-box instances, i.e. nibbles substituted per cycle; must divide `SIZE/4`.
- Derived `K = SIZE/(4*LANES)`: substitution cycles per block. The counter width is `max(1, clog2(K))`.

Ports:

- `clk`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset. Asserting it (0) immediately clears all state; release is synchronous to `clk` externally.
- `in_valid`, in, 1: upstream block is valid.
- `in_ready`, out, 1: block can be accepted.
- `in_data`, in, `SIZE`: state to substitute.
- `inverse`, in, 1: 0 selects the forward S-box, 1 selects the inverse S-box; sampled with `in_data`.
- `out_valid`, out, 1: result is valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_data`, out, `SIZE`: substituted state.
- `busy`, out, 1: high whenever not in IDLE.

## Operation

- Forward S-box, indexed by input nibble 0..F: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- Inverse S-box, indexed by input nibble 0..F: 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
- The working register `state_q` is `SIZE` bits wide. It drives `out_data` directly, with no separate output register.
- The FSM has three states: IDLE, SUB, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready` at a rising edge: load `state_q <= in_data`, latch `mode_q <= inverse`, set `cnt <= 0`, go to SUB.
- SUB:
  - Each edge replaces nibbles `[cnt*LANES .. cnt*LANES+LANES-1]` of `state_q` with their S-box images. Nibble 0 is bits [3:0], so processing runs least-significant first.
  - All other nibbles hold.
  - `cnt` increments each edge.
  - On the edge where `cnt == K-1`, go to DONE.
- DONE:
  - `out_valid` = 1 and `out_data` is stable.
  - On `out_valid && out_ready` at an edge, go to IDLE.
  - While `out_ready` = 0, hold indefinitely.
- `in_ready` = 0 in SUB and DONE. `in_valid` in those states is ignored, with no capture and no side effect.
- `mode_q` is fixed for the whole block. Toggling `inverse` after acceptance has no effect.
- No in/out overlap: a new block is accepted only from IDLE.
- Reset values, all forced by asynchronous assertion of `reset`:
  - state = IDLE
  - `state_q` = 0, so `out_data` = 0
  - `cnt` = 0
  - `mode_q` = 0
  - `out_valid` = 0
  - `busy` = 0
  - `in_ready` = 0 while `reset` = 0, then 1 once released in IDLE.
- Reset mid-SUB or mid-DONE: the partial result is discarded and no `out_valid` pulse is produced.

## Timing

- Latency: a block accepted at edge t0 shows `out_valid` = 1 in the cycle after edge t0+K.
- For `K` = 1, the whole state is substituted at edge t0+1.
- Minimum initiation interval is K+2 cycles, with `out_ready` held at 1: accept at t0, output handshake at t0+K+1, back in IDLE, next accept at t0+K+2.
- All outputs are registered or decoded from FSM state only. There is no combinational path from `in_*` to `out_*`, or from `out_ready` to `in_ready`.
- Intermediate `out_data` values during SUB are visible but meaningless; consumers use them only when `out_valid` = 1.

## Test plan

- Forward, `SIZE` 16, `LANES` 1: `in_data` 0x0123, `inverse` 0 -> `out_data` 0xC56B with `out_valid` rising exactly 4 cycles after acceptance; `busy` high throughout.
- Inverse round trip, `SIZE` 16, `LANES` 1: feed 0xC56B with `inverse` 1 -> 0x0123. Also feed 0xFFFF with `inverse` 0 -> 0x2222.
- Wide and parallel, `SIZE` 64, `LANES` 4: 0x0123456789ABCDEF forward -> 0xC56B90AD3EF84712 after exactly 4 cycles. Inverse of that result -> the original value.
- Backpressure: hold `out_ready` = 0 for 10 cycles in DONE -> `out_valid` and `out_data` stay stable and `in_ready` stays 0. Pulse `in_valid` with 0xAAAA during that window -> ignored, next output unaffected. Raise `out_ready` -> IDLE one edge later.
- Mode latch and back-to-back: accept 0x0123 forward, then toggle `inverse` during SUB -> result is still 0xC56B. With `out_ready` = 1 and `in_valid` held, the second accept occurs K+2 cycles after the first.
- Reset mid-operation: assert `reset` = 0 during cycle 2 of SUB -> `out_data` = 0, `out_valid` = 0, `busy` = 0 immediately, without waiting for a clock edge. After release, 0x4567 forward -> 0x90AD.
